dma_mem_responder: RTL and testbench
====================================

// Module: dma_mem_responder
// PURPOSE
//   Memory-side responder for the bulk-transfer arb_* request interface issued by the NTT cores.
//   Accepts one whole-vector request (LOAD, LOAD_W, STORE, perf dump) and serialises it into
//   word transactions on a pipelined memory port. It then returns the result in one array and
//   pulses arb_ack. One instance serves one requester; multi-core muxing sits upstream.
// PARAMETERS
//   N        4096  polynomial length; rdata/wdata arrays hold 2*N words (twiddle load size)
//   MAX_OUT  8     maximum outstanding memory reads (credit limit, 1..15)
//   STRIDE   8     byte increment of mem_addr per 64-bit word
// PORTS
//   clk         in   1        single clock
//   rst         in   1        asynchronous, active-high reset
//   arb_req     in   1        request; held high until arb_ack seen
//   arb_rw      in   1        0 = read from memory, 1 = write to memory
//   arb_addr    in   48       byte base address
//   arb_len     in   32       word count
//   arb_wdata   in   64x2N    write payload; stable while arb_req high
//   arb_rdata   out  64x2N    read payload; valid when arb_ack pulses
//   arb_ack     out  1        one-cycle completion pulse
//   arb_err     out  1        high with arb_ack when request rejected
//   busy        out  1        high in any state except IDLE
//   mem_req     out  1        memory command valid
//   mem_we      out  1        1 = write command
//   mem_addr    out  48       word address in bytes
//   mem_wdata   out  64       write data
//   mem_gnt     in   1        command accepted when mem_req & mem_gnt
//   mem_rvalid  in   1        read data return, in issue order
//   mem_rdata   in   64       read data
// BEHAVIOUR
//   Reset: arb_ack, arb_err, busy, mem_req, mem_we = 0. mem_addr, mem_wdata = 0. All counters = 0.
//     State = IDLE. arb_rdata is storage: not cleared, so its content after reset is don't-care.
//   States: IDLE -> RD | WR | ACK; RD -> ACK; WR -> ACK; ACK -> RELEASE; RELEASE -> IDLE.
//   IDLE: on arb_req=1, latch rw, addr, len; clear issue_cnt, rcv_cnt, outstanding.
//     len==0 -> ACK with arb_err=0 and no memory traffic.
//     len>2N -> ACK with arb_err=1 and no memory traffic.
//     Otherwise go to RD (rw=0) or WR (rw=1).
//   Addressing: mem_addr = base + STRIDE*issue_cnt, modulo 2^48 (wraps silently).
//   RD state:
//     - mem_req=1 while issue_cnt<len and outstanding<MAX_OUT; mem_we=0.
//     - On mem_req&mem_gnt: issue_cnt+1 and outstanding+1.
//     - On mem_rvalid: write arb_rdata[rcv_cnt]=mem_rdata; rcv_cnt+1; outstanding-1.
//     - Grant and rvalid in the same cycle: outstanding unchanged.
//     - mem_rvalid when outstanding==0 is ignored; no write, no count.
//     - rcv_cnt==len -> ACK.
//   WR state:
//     - mem_req=1, mem_we=1, mem_wdata=arb_wdata[issue_cnt] while issue_cnt<len.
//     - Advance on gnt; writes are posted.
//     - Last grant -> ACK.
//   Command holding: mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and gnt=0.
//   ACK: arb_ack=1 for exactly one cycle; arb_err as decided in IDLE, cleared in next state.
//   RELEASE: wait until arb_req==0, then go to IDLE. A held req never retriggers.
//   Latency: len=1 read with 1-cycle memory -> ack 4 cycles after req sampled.
//   Throughput: one word/cycle when gnt is always high and return latency <= MAX_OUT.
//   Reset mid-operation: abort at once; mem_req drops asynchronously.
//     Outstanding returns arriving after reset are ignored (IDLE drops rvalid).
//   Counters are 14 bits (hold 2N=8192). outstanding is 4 bits.
// STRUCTURE
//   fhe_dma_pkg:
//     - state enum {IDLE,RD,WR,ACK,RELEASE}
//     - ADDR_W=48, LEN_W=32, DATA_W=64
//     - shared by ntt cores and the upstream arbiter
//   Sub-module dma_credit_ctr: up/down outstanding counter with MAX_OUT limit and can_issue output.
// TESTING
//   1. Read, len=4, addr=0x1000, 1-cycle memory with gnt=1:
//      mem_addr 0x1000,0x1008,0x1010,0x1018; rdata[0..3]=returned words; single ack.
//   2. Write, len=4, wdata=0xA..0xD, gnt low on 2nd command for 3 cycles:
//      command held stable; 4 writes in order; ack after last grant.
//   3. Read, len=8192, memory latency 12:
//      outstanding never exceeds 8; all 8192 words land correctly.
//   4. len=0 -> ack=1, err=0, no mem_req.
//      len=8193 -> ack=1, err=1, no mem_req.
//   5. arb_req held high 5 cycles after ack: exactly one ack, one transfer.
//   6. Reset asserted in RD at issue_cnt=3:
//      - mem_req=0 immediately; state IDLE.
//      - Late rvalid ignored.
//      - Next len=2 read succeeds.

Source files
------------

// File: rtl/fhe_dma_pkg.sv
// Shared types and widths for the DMA request path between the NTT cores, the
// upstream arbiter and the memory-side responder.
package fhe_dma_pkg;

  localparam int ADDR_W = 48;
  localparam int LEN_W  = 32;
  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    ACK,
    RELEASE
  } state_t;

  // Byte address of word idx in a transfer; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] idx,
                                                  input int stride);
    return base + idx * ADDR_W'(stride);
  endfunction

endpackage

// File: rtl/dma_mem_responder_if.sv
// Pipelined memory port between the DMA responder (master) and memory (slave).
// A command transfers on a rising edge where mem_req & mem_gnt are both high; while
// mem_req is high and mem_gnt low the command (addr, we, wdata) is held unchanged.
// mem_rvalid has no back-pressure and returns read data strictly in issue order.
interface dma_mem_responder_if;

  logic                             mem_req;
  logic                             mem_we;
  logic [fhe_dma_pkg::ADDR_W-1:0]   mem_addr;
  logic [fhe_dma_pkg::DATA_W-1:0]   mem_wdata;
  logic                             mem_gnt;
  logic                             mem_rvalid;
  logic [fhe_dma_pkg::DATA_W-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/dma_credit_ctr.sv
// Outstanding-read counter: counts issued reads not yet returned and gates new
// issues once MAX_OUT reads are in flight.
module dma_credit_ctr #(
  parameter int MAX_OUT = 8,
  parameter int W       = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         can_issue
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      // Simultaneous issue and return leaves the count unchanged.
      case ({inc, dec})
        2'b10:   count <= count + W'(1);
        2'b01:   count <= count - W'(1);
        default: count <= count;
      endcase
    end
  end

  assign can_issue = (count < W'(MAX_OUT));

endmodule

// File: rtl/dma_mem_responder.sv
// Serialises one whole-vector arb_* request into word commands on the memory port,
// gathers read returns into arb_rdata and pulses arb_ack when the transfer is done.
module dma_mem_responder
  import fhe_dma_pkg::*;
#(
  parameter int N       = 4096,
  parameter int MAX_OUT = 8,
  parameter int STRIDE  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arb_req,
  input  logic                arb_rw,
  input  logic [ADDR_W-1:0]   arb_addr,
  input  logic [LEN_W-1:0]    arb_len,
  input  logic [DATA_W-1:0]   arb_wdata [2*N],
  output logic [DATA_W-1:0]   arb_rdata [2*N],
  output logic                arb_ack,
  output logic                arb_err,
  output logic                busy,
  output state_t              dbg_state,
  dma_mem_responder_if.master mem
);

  localparam int WORDS = 2 * N;
  localparam int CNT_W = $clog2(WORDS + 1);
  localparam int IDX_W = $clog2(WORDS);

  state_t           state, state_nxt;
  logic             rw_q, err_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0] len_q, issue_cnt, rcv_cnt;
  logic [3:0]       outstanding;
  logic             can_issue;
  logic             start, grant, accept, more;

  assign start  = (state == IDLE) && arb_req;
  assign grant  = mem.mem_req && mem.mem_gnt;
  assign more   = (issue_cnt < len_q);
  // Returns with nothing in flight (including stale ones after reset) are dropped.
  assign accept = (state == RD) && mem.mem_rvalid && (outstanding != 4'd0);

  dma_credit_ctr #(.MAX_OUT(MAX_OUT), .W(4)) u_credit (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .inc       (grant && (state == RD)),
    .dec       (accept),
    .count     (outstanding),
    .can_issue (can_issue)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q      <= 1'b0;
      err_q     <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
    end else if (start) begin
      rw_q      <= arb_rw;
      err_q     <= (arb_len > LEN_W'(WORDS));
      base_q    <= arb_addr;
      len_q     <= arb_len[CNT_W-1:0];
      issue_cnt <= '0;
      rcv_cnt   <= '0;
    end else begin
      if (grant)  issue_cnt <= issue_cnt + CNT_W'(1);
      if (accept) rcv_cnt   <= rcv_cnt + CNT_W'(1);
    end
  end

  // Result storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) arb_rdata[rcv_cnt[IDX_W-1:0]] <= mem.mem_rdata;
  end

  always_comb begin
    state_nxt     = state;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_wdata = '0;
    mem.mem_addr  = word_addr(base_q, ADDR_W'(issue_cnt), STRIDE);
    arb_ack       = 1'b0;
    arb_err       = 1'b0;
    busy          = (state != IDLE);
    dbg_state     = state;
    case (state)
      IDLE: begin
        if (arb_req) begin
          if (arb_len == '0)                     state_nxt = ACK;
          else if (arb_len > LEN_W'(WORDS))      state_nxt = ACK;
          else                                   state_nxt = arb_rw ? WR : RD;
        end
      end
      RD: begin
        mem.mem_req = more && can_issue;
        if (rcv_cnt == len_q) state_nxt = ACK;
      end
      WR: begin
        mem.mem_req   = more;
        mem.mem_we    = more;
        mem.mem_wdata = more ? arb_wdata[issue_cnt[IDX_W-1:0]] : '0;
        if (grant && ((issue_cnt + CNT_W'(1)) == len_q)) state_nxt = ACK;
      end
      ACK: begin
        arb_ack   = 1'b1;
        arb_err   = err_q;
        state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!arb_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic unused_rw;
  assign unused_rw = rw_q;

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench for dma_mem_responder: table of whole-vector transfers against a
// latency-programmable memory model, plus hand-written stall and reset sequences.
module tb_dma_mem_responder;
  import fhe_dma_pkg::*;

  localparam int N       = 4096;
  localparam int WORDS   = 2 * N;
  localparam int MAX_OUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              arb_req = 1'b0;
  logic              arb_rw = 1'b0;
  logic [47:0]       arb_addr = '0;
  logic [31:0]       arb_len = '0;
  logic [63:0]       arb_wdata [WORDS];
  logic [63:0]       arb_rdata [WORDS];
  logic              arb_ack, arb_err, busy;
  state_t            dbg_state;

  dma_mem_responder_if mem_if ();

  dma_mem_responder #(.N(N), .MAX_OUT(MAX_OUT), .STRIDE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .arb_req   (arb_req),
    .arb_rw    (arb_rw),
    .arb_addr  (arb_addr),
    .arb_len   (arb_len),
    .arb_wdata (arb_wdata),
    .arb_rdata (arb_rdata),
    .arb_ack   (arb_ack),
    .arb_err   (arb_err),
    .busy      (busy),
    .dbg_state (dbg_state),
    .mem       (mem_if)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int ec = 0;
  int lat = 1;
  int grants = 0;
  int req_cycles = 0;
  int tb_out = 0;
  int max_out = 0;
  int stall_after = 0;
  int stall_len = 0;
  int stall_cnt = 0;
  int last_grant_ec = 0;
  logic inj_rvalid = 1'b0;
  logic rv_real = 1'b0;
  logic hold_pending = 1'b0;
  logic [47:0] hold_addr;
  logic        hold_we;
  logic [63:0] hold_wdata;

  logic [47:0] cmd_addr_q[$];
  logic        cmd_we_q[$];
  logic [63:0] cmd_data_q[$];
  logic [47:0] exp_q[$];
  int          pend_due[$];
  logic [47:0] pend_addr[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [47:0] a);
    return {16'hC0DE, a} ^ {a[15:0], 48'h0};
  endfunction

  // ---------------- memory model ----------------
  always @(posedge clk) begin
    ec++;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("cmd_hold_req",   64'(mem_if.mem_req),  64'd1);
        check("cmd_hold_addr",  64'(mem_if.mem_addr), 64'(hold_addr));
        check("cmd_hold_we",    64'(mem_if.mem_we),   64'(hold_we));
        check("cmd_hold_wdata", mem_if.mem_wdata,     hold_wdata);
      end
      hold_pending = mem_if.mem_req && !mem_if.mem_gnt;
      hold_addr    = mem_if.mem_addr;
      hold_we      = mem_if.mem_we;
      hold_wdata   = mem_if.mem_wdata;
      if (mem_if.mem_req) req_cycles++;
      if (mem_if.mem_rvalid && rv_real && tb_out > 0) tb_out--;
      if (mem_if.mem_req && mem_if.mem_gnt) begin
        grants++;
        last_grant_ec = ec;
        cmd_addr_q.push_back(mem_if.mem_addr);
        cmd_we_q.push_back(mem_if.mem_we);
        cmd_data_q.push_back(mem_if.mem_wdata);
        if (!mem_if.mem_we) begin
          pend_due.push_back(ec + lat - 1);
          pend_addr.push_back(mem_if.mem_addr);
          tb_out++;
        end
        if (grants == stall_after) stall_cnt = stall_len;
      end
      if (tb_out > max_out) max_out = tb_out;
    end
  end

  always @(negedge clk) begin
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = '0;
    rv_real           = 1'b0;
    if (pend_due.size() > 0 && pend_due[0] <= ec) begin
      void'(pend_due.pop_front());
      mem_if.mem_rdata  = mem_word(pend_addr.pop_front());
      mem_if.mem_rvalid = 1'b1;
      rv_real           = 1'b1;
    end else if (inj_rvalid && busy) begin
      mem_if.mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
      mem_if.mem_rvalid = 1'b1;
      inj_rvalid        = 1'b0;
    end
    if (stall_cnt > 0) begin
      mem_if.mem_gnt = 1'b0;
      stall_cnt--;
    end else begin
      mem_if.mem_gnt = 1'b1;
    end
  end

  // ---------------- driver ----------------
  typedef struct {
    logic        rw;
    logic [47:0] addr;
    logic [31:0] len;
    int          lat;
    int          hold;
    logic        inj;
    logic        exp_err;
    int          exp_cmds;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic clear_logs();
    cmd_addr_q.delete();
    cmd_we_q.delete();
    cmd_data_q.delete();
    exp_q.delete();
    grants = 0;
    req_cycles = 0;
    tb_out = 0;
    max_out = 0;
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic run_xfer(input vec_t v, output int acks, output logic err,
                          output int ack_ec, output int sample_ec);
    int n;
    lat = v.lat;
    clear_logs();
    inj_rvalid = v.inj;
    arb_rw   = v.rw;
    arb_addr = v.addr;
    arb_len  = v.len;
    arb_req  = 1'b1;
    sample_ec = ec + 1;
    acks = 0;
    err = 1'b0;
    ack_ec = -1;
    n = 0;
    while (acks == 0 && n < 30000) begin
      @(posedge clk); #1;
      n++;
      if (arb_ack) begin
        acks++;
        err = arb_err;
        ack_ec = ec;
      end
    end
    if (acks == 0) check("ack_timeout", 64'(n), 64'd0);
    repeat (v.hold) begin
      @(posedge clk); #1;
      if (arb_ack) acks++;
    end
    arb_req = 1'b0;
    inj_rvalid = 1'b0;
    n = 0;
    while ((busy || pend_due.size() > 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("return_to_idle", 64'(busy), 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int acks, ack_ec, sample_ec, n, busy_seen;
    logic err;
    logic [47:0] ea;

    for (int i = 0; i < WORDS; i++) arb_wdata[i] = 64'h1111_0000_0000_0000 + 64'(i);

    vecs[0] = '{rw:1'b0, addr:48'h1000, len:32'd4, lat:1, hold:0, inj:1'b0, exp_err:1'b0, exp_cmds:4, exp_lat:-1};
    vecs[1] = '{rw:1'b0, addr:48'h1_0000, len:32'd1, lat:1, hold:0, inj:1'b0, exp_err:1'b0, exp_cmds:1, exp_lat:4};
    vecs[2] = '{rw:1'b0, addr:48'h2000, len:32'd8192, lat:12, hold:0, inj:1'b0, exp_err:1'b0, exp_cmds:8192, exp_lat:-1};
    vecs[3] = '{rw:1'b0, addr:48'h2000, len:32'd0, lat:1, hold:0, inj:1'b0, exp_err:1'b0, exp_cmds:0, exp_lat:-1};
    vecs[4] = '{rw:1'b1, addr:48'h2000, len:32'd8193, lat:1, hold:0, inj:1'b0, exp_err:1'b1, exp_cmds:0, exp_lat:-1};
    vecs[5] = '{rw:1'b0, addr:48'h3000, len:32'd3, lat:2, hold:5, inj:1'b0, exp_err:1'b0, exp_cmds:3, exp_lat:-1};
    vecs[6] = '{rw:1'b0, addr:48'hFFFF_FFFF_FFF0, len:32'd4, lat:3, hold:0, inj:1'b0, exp_err:1'b0, exp_cmds:4, exp_lat:-1};
    vecs[7] = '{rw:1'b1, addr:48'h5000, len:32'd5, lat:1, hold:0, inj:1'b0, exp_err:1'b0, exp_cmds:5, exp_lat:-1};
    vecs[8] = '{rw:1'b0, addr:48'h8000, len:32'd2, lat:3, hold:0, inj:1'b1, exp_err:1'b0, exp_cmds:2, exp_lat:-1};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   64'(arb_ack),         64'd0);
    check("rst_err",   64'(arb_err),         64'd0);
    check("rst_busy",  64'(busy),            64'd0);
    check("rst_req",   64'(mem_if.mem_req),  64'd0);
    check("rst_we",    64'(mem_if.mem_we),   64'd0);
    check("rst_addr",  64'(mem_if.mem_addr), 64'd0);
    check("rst_wdata", mem_if.mem_wdata,     64'd0);
    check("rst_state", 64'(dbg_state),       64'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven transfers
    for (int t = 0; t < 9; t++) begin
      run_xfer(vecs[t], acks, err, ack_ec, sample_ec);
      check($sformatf("v%0d_acks", t), 64'(acks), 64'd1);
      check($sformatf("v%0d_err", t),  64'(err),  64'(vecs[t].exp_err));
      check($sformatf("v%0d_cmds", t), 64'(cmd_addr_q.size()), 64'(vecs[t].exp_cmds));
      if (vecs[t].exp_cmds == 0)
        check($sformatf("v%0d_no_req", t), 64'(req_cycles), 64'd0);
      if (vecs[t].exp_lat >= 0)
        check($sformatf("v%0d_latency", t), 64'(ack_ec + 1 - sample_ec), 64'(vecs[t].exp_lat));
      if (!vecs[t].rw && vecs[t].exp_cmds > 0)
        check($sformatf("v%0d_max_out_ok", t), 64'(max_out <= MAX_OUT), 64'd1);
      for (int i = 0; i < vecs[t].exp_cmds; i++) exp_q.push_back(vecs[t].addr + 48'(8 * i));
      for (int i = 0; i < vecs[t].exp_cmds && cmd_addr_q.size() > 0; i++) begin
        ea = exp_q.pop_front();
        check($sformatf("v%0d_addr%0d", t, i), 64'(cmd_addr_q.pop_front()), 64'(ea));
        check($sformatf("v%0d_we%0d", t, i),   64'(cmd_we_q.pop_front()),   64'(vecs[t].rw));
        if (vecs[t].rw)
          check($sformatf("v%0d_wdata%0d", t, i), cmd_data_q.pop_front(), arb_wdata[i]);
        else
          check($sformatf("v%0d_rdata%0d", t, i), arb_rdata[i], mem_word(ea));
      end
    end

    // Write with grant held low for 3 cycles on the second command
    for (int i = 0; i < 4; i++) arb_wdata[i] = 64'hA + 64'(i);
    stall_after = 1;
    stall_len   = 3;
    run_xfer('{rw:1'b1, addr:48'h9000, len:32'd4, lat:1, hold:0, inj:1'b0, exp_err:1'b0, exp_cmds:4, exp_lat:-1},
             acks, err, ack_ec, sample_ec);
    stall_after = 0;
    check("wstall_acks", 64'(acks), 64'd1);
    check("wstall_cmds", 64'(cmd_addr_q.size()), 64'd4);
    check("wstall_ack_after_last_grant", 64'(ack_ec), 64'(last_grant_ec));
    check("wstall_req_cycles", 64'(req_cycles), 64'd7);
    for (int i = 0; i < 4 && cmd_addr_q.size() > 0; i++) begin
      check($sformatf("wstall_addr%0d", i),  64'(cmd_addr_q.pop_front()), 64'(48'h9000 + 48'(8 * i)));
      check($sformatf("wstall_wdata%0d", i), cmd_data_q.pop_front(), 64'hA + 64'(i));
    end

    // Reset in the middle of a read once three commands have issued
    lat = 12;
    clear_logs();
    arb_rw = 1'b0; arb_addr = 48'h6000; arb_len = 32'd8; arb_req = 1'b1;
    n = 0;
    while (grants < 3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_grants", 64'(grants), 64'd3);
    check("mid_req_before", 64'(mem_if.mem_req), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_req_dropped", 64'(mem_if.mem_req), 64'd0);
    check("mid_busy",        64'(busy),           64'd0);
    check("mid_state",       64'(dbg_state),      64'(IDLE));
    arb_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    busy_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy || arb_ack) busy_seen++;
    end
    check("late_rvalid_ignored", 64'(busy_seen), 64'd0);
    check("late_rvalid_drained", 64'(pend_due.size()), 64'd0);
    run_xfer('{rw:1'b0, addr:48'h7000, len:32'd2, lat:1, hold:0, inj:1'b0, exp_err:1'b0, exp_cmds:2, exp_lat:-1},
             acks, err, ack_ec, sample_ec);
    check("post_rst_acks",  64'(acks), 64'd1);
    check("post_rst_cmds",  64'(cmd_addr_q.size()), 64'd2);
    check("post_rst_rdata0", arb_rdata[0], mem_word(48'h7000));
    check("post_rst_rdata1", arb_rdata[1], mem_word(48'h7008));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
